// File: rtl/compound_type_accumulator.sv
// ----------------------------------------------------------------------------
// Module      : compound_type_accumulator
// Description : Consumes CompoundType {mode, x, y} messages. Writes add to or
//               load a signed accumulator; reads return it downstream.
// Revision    : 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module compound_type_accumulator #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  // Packed CompoundType: [DATA_W+1] = mode, [DATA_W:1] = x, [0] = y
  input  logic [DATA_W+1:0] b_in,
  input  logic              b_in_sync,
  output logic              b_in_notify,
  output logic [DATA_W-1:0] r_out,
  input  logic              r_out_sync,
  output logic              r_out_notify,
  output logic [CNT_W-1:0]  op_count,
  output logic              busy
);

  localparam logic c_MODE_READ  = 1'b0;
  localparam logic c_MODE_WRITE = 1'b1;

  localparam logic [CNT_W-1:0]  c_CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0]  c_CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [DATA_W-1:0] c_ACC_ZERO = {DATA_W{1'b0}};

  typedef enum logic [0:0] {
    SECTION_IDLE = 1'b0,
    SECTION_SEND = 1'b1
  } section_t;

  section_t            r_section;
  section_t            w_section_nxt;
  logic [DATA_W-1:0]   r_acc;
  logic [DATA_W-1:0]   w_acc_nxt;
  logic                r_clr_pending;
  logic                w_clr_pending_nxt;
  logic [DATA_W-1:0]   w_r_out_nxt;
  logic                w_r_out_notify_nxt;
  logic                w_b_in_notify_nxt;
  logic                w_busy_nxt;
  logic [CNT_W-1:0]    w_op_count_nxt;

  logic                w_in_xfer;
  logic                w_out_xfer;
  logic                w_mode;
  logic [DATA_W-1:0]   w_x;
  logic                w_y;

  assign w_mode     = b_in[DATA_W+1];
  assign w_x        = b_in[DATA_W:1];
  assign w_y        = b_in[0];
  assign w_in_xfer  = b_in_sync & b_in_notify;
  assign w_out_xfer = r_out_notify & r_out_sync;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_section     <= SECTION_IDLE;
      r_acc         <= c_ACC_ZERO;
      r_clr_pending <= 1'b0;
      r_out         <= c_ACC_ZERO;
      r_out_notify  <= 1'b0;
      b_in_notify   <= 1'b1;
      busy          <= 1'b0;
      op_count      <= {CNT_W{1'b0}};
    end else begin
      r_section     <= w_section_nxt;
      r_acc         <= w_acc_nxt;
      r_clr_pending <= w_clr_pending_nxt;
      r_out         <= w_r_out_nxt;
      r_out_notify  <= w_r_out_notify_nxt;
      b_in_notify   <= w_b_in_notify_nxt;
      busy          <= w_busy_nxt;
      op_count      <= w_op_count_nxt;
    end
  end

  always_comb begin
    w_section_nxt      = r_section;
    w_acc_nxt          = r_acc;
    w_clr_pending_nxt  = r_clr_pending;
    w_r_out_nxt        = r_out;
    w_r_out_notify_nxt = r_out_notify;
    w_b_in_notify_nxt  = b_in_notify;
    w_busy_nxt         = busy;

    case (r_section)
      SECTION_IDLE: begin
        if (w_in_xfer) begin
          if (w_mode == c_MODE_WRITE) begin
            // y selects accumulate (1) versus load (0); addition wraps
            w_acc_nxt = w_y ? (r_acc + w_x) : w_x;
          end else begin
            w_r_out_nxt        = r_acc;
            w_clr_pending_nxt  = w_y;
            w_b_in_notify_nxt  = 1'b0;
            w_r_out_notify_nxt = 1'b1;
            w_busy_nxt         = 1'b1;
            w_section_nxt      = SECTION_SEND;
          end
        end
      end
      SECTION_SEND: begin
        if (w_out_xfer) begin
          w_r_out_notify_nxt = 1'b0;
          w_b_in_notify_nxt  = 1'b1;
          w_busy_nxt         = 1'b0;
          w_clr_pending_nxt  = 1'b0;
          w_section_nxt      = SECTION_IDLE;
          if (r_clr_pending) begin
            w_acc_nxt = c_ACC_ZERO;
          end
        end
      end
      default: begin
        w_section_nxt = SECTION_IDLE;
      end
    endcase
  end

  always_comb begin
    w_op_count_nxt = op_count;
    if (w_in_xfer && (op_count != c_CNT_MAX)) begin
      w_op_count_nxt = op_count + c_CNT_ONE;
    end
  end

endmodule

`default_nettype wire
